// File: rtl/matrix_row_argmax_if.sv
// Handshake and RAM-port bundle between the row-argmax scanner and its environment.
// master: the scanner (drives RAM address, status and results); slave: RAM/consumer side.
// Pure wiring, no state.
interface matrix_row_argmax_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] z_data;
  logic [ADDR_WIDTH-1:0] z_addr;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_row;
  logic [ADDR_WIDTH-1:0] out_index;
  logic [DATA_WIDTH-1:0] out_value;
  logic                  done;

  modport master (
    input  start, z_data, out_ready,
    output z_addr, busy, out_valid, out_row, out_index, out_value, done
  );

  modport slave (
    output start, z_data, out_ready,
    input  z_addr, busy, out_valid, out_row, out_index, out_value, done
  );
endinterface

// File: rtl/matrix_row_argmax.sv
// Scans a row-major Z RAM and emits (row, argmax column, max value) per row.
// Latency: 2*NUM_COLS cycles per row plus one EMIT cycle; +1 FIN cycle pulsing done.
// Backpressure: EMIT holds results and freezes all counters until out_ready.
// Option macro ARGMAX_SIGNED_COMPARE_EN: compare elements as signed (default unsigned).
module matrix_row_argmax #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROWS   = 5,
  parameter int NUM_COLS   = 5
) (
  input logic                  clk,
  input logic                  rst,
  matrix_row_argmax_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(NUM_COLS - 1);

  typedef enum logic [2:0] {IDLE, READ, CMP, EMIT, FIN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] row_q;
  logic [ADDR_WIDTH-1:0] col_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] index_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic                  greater;
  logic                  scan_busy;
  logic                  result_vld;
  logic                  scan_done;

  // Element comparison; strict so ties keep the lowest column.
  always_comb begin
`ifdef ARGMAX_SIGNED_COMPARE_EN
    greater = $signed(bus.z_data) > $signed(max_q);
`else
    greater = bus.z_data > max_q;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = READ;
      READ: state_nxt = CMP;
      CMP:  if (col_q == LAST_COL) state_nxt = EMIT;
            else                   state_nxt = READ;
      EMIT: if (bus.out_ready) state_nxt = (row_q == LAST_ROW) ? FIN : READ;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    scan_busy  = 1'b0;
    result_vld = 1'b0;
    scan_done  = 1'b0;
    case (state)
      READ, CMP: scan_busy = 1'b1;
      EMIT:      begin scan_busy = 1'b1; result_vld = 1'b1; end
      FIN:       scan_done = 1'b1;
      default:   ;
    endcase
  end

  // Counters, RAM address and running max; address advances in lock-step with col/row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      index_q <= '0;
      max_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          row_q  <= '0;
          col_q  <= '0;
          addr_q <= '0;
        end
        CMP: begin
          if (col_q == '0 || greater) begin
            max_q   <= bus.z_data;
            index_q <= col_q;
          end
          if (col_q != LAST_COL) begin
            col_q  <= col_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        EMIT: if (bus.out_ready && row_q != LAST_ROW) begin
          row_q  <= row_q + 1'b1;
          col_q  <= '0;
          addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.z_addr    = addr_q;
  assign bus.busy      = scan_busy;
  assign bus.out_valid = result_vld;
  assign bus.done      = scan_done;
  assign bus.out_row   = row_q;
  assign bus.out_index = index_q;
  assign bus.out_value = max_q;

endmodule

// File: tb/tb_matrix_row_argmax.sv
// Directed bench for matrix_row_argmax with a 2x3 matrix and a 1-cycle-latency RAM.
// Each scenario task drives a scan and checks results against hand-computed values.
module tb_matrix_row_argmax;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  logic [DW-1:0] mem [0:5];
  logic [AW-1:0] res_row [0:3];
  logic [AW-1:0] res_idx [0:3];
  logic [DW-1:0] res_val [0:3];
  int            res_cnt;
  int            done_cnt;
  int            done_cycle;

  matrix_row_argmax_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  matrix_row_argmax #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ROWS(2), .NUM_COLS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (bus.z_addr < AW'(6)) bus.z_data <= mem[bus.z_addr];
    else                     bus.z_data <= '0;
  end

  task automatic load(input logic [DW-1:0] a, b, c, d, e, f);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d; mem[4] = e; mem[5] = f;
  endtask

  // One full scan from IDLE; optional stall on the first EMIT, stray start pulse, reset abort.
  task automatic do_scan(input int stall, input int inject_at, input int abort_at);
    int            stall_left;
    bit            rdy;
    bit            have_snap;
    logic [AW-1:0] s_row, s_idx;
    logic [DW-1:0] s_val;
    stall_left = stall; have_snap = 0;
    res_cnt = 0; done_cnt = 0; done_cycle = -1;
    s_row = '0; s_idx = '0; s_val = '0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 1) begin
        tests_run++;
        if (bus.busy !== 1'b1 || bus.z_addr !== AW'(0)) begin
          tests_failed++;
          $display("FAIL busy_after_start: busy=%b z_addr=%0d, required busy=1 z_addr=0", bus.busy, bus.z_addr);
        end
      end
      if (n == abort_at) begin
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.z_addr !== '0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0 ||
            bus.out_row !== '0 || bus.out_index !== '0 || bus.out_value !== '0) begin
          tests_failed++;
          $display("FAIL abort_outputs_zero: addr=%0d busy=%b vld=%b done=%b row=%0d idx=%0d val=%0h, required all 0",
                   bus.z_addr, bus.busy, bus.out_valid, bus.done, bus.out_row, bus.out_index, bus.out_value);
        end
        @(negedge clk);
        if (bus.done) done_cnt++;
        rst = 1'b1;
        return;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = n;
      end
      bus.start = (n == inject_at);
      rdy = 1'b1;
      if (bus.out_valid && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        tests_run++;
        if (bus.z_addr !== AW'(2)) begin
          tests_failed++;
          $display("FAIL stall_addr_frozen: z_addr=%0d, required 2", bus.z_addr);
        end
        if (!have_snap) begin
          have_snap = 1; s_row = bus.out_row; s_idx = bus.out_index; s_val = bus.out_value;
        end else begin
          tests_run++;
          if (bus.out_row !== s_row || bus.out_index !== s_idx || bus.out_value !== s_val) begin
            tests_failed++;
            $display("FAIL stall_stable: row=%0d idx=%0d val=%0h, required row=%0d idx=%0d val=%0h",
                     bus.out_row, bus.out_index, bus.out_value, s_row, s_idx, s_val);
          end
        end
      end
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        if (res_cnt < 4) begin
          res_row[res_cnt] = bus.out_row;
          res_idx[res_cnt] = bus.out_index;
          res_val[res_cnt] = bus.out_value;
        end
        res_cnt++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_results(input string name, input int exp_done,
                               input logic [AW-1:0] i0, input logic [DW-1:0] v0,
                               input logic [AW-1:0] i1, input logic [DW-1:0] v1);
    tests_run++;
    if (res_cnt !== 2) begin
      tests_failed++;
      $display("FAIL %s_count: %0d results, required 2", name, res_cnt);
    end else begin
      tests_run++;
      if (res_row[0] !== AW'(0) || res_idx[0] !== i0 || res_val[0] !== v0) begin
        tests_failed++;
        $display("FAIL %s_row0: row=%0d idx=%0d val=%0h, required row=0 idx=%0d val=%0h",
                 name, res_row[0], res_idx[0], res_val[0], i0, v0);
      end
      tests_run++;
      if (res_row[1] !== AW'(1) || res_idx[1] !== i1 || res_val[1] !== v1) begin
        tests_failed++;
        $display("FAIL %s_row1: row=%0d idx=%0d val=%0h, required row=1 idx=%0d val=%0h",
                 name, res_row[1], res_idx[1], res_val[1], i1, v1);
      end
    end
    tests_run++;
    if (done_cnt !== 1 || done_cycle !== exp_done) begin
      tests_failed++;
      $display("FAIL %s_done: pulses=%0d cycle=%0d, required pulses=1 cycle=%0d", name, done_cnt, done_cycle, exp_done);
    end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.z_addr !== AW'(5)) begin
      tests_failed++;
      $display("FAIL %s_idle_after: busy=%b z_addr=%0d, required busy=0 z_addr=5", name, bus.busy, bus.z_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.z_addr !== '0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.out_row !== '0 || bus.out_index !== '0 || bus.out_value !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: addr=%0d busy=%b vld=%b done=%b row=%0d idx=%0d val=%0h, required all 0",
               bus.z_addr, bus.busy, bus.out_valid, bus.done, bus.out_row, bus.out_index, bus.out_value);
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_without_start: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    load(32'd3, 32'd9, 32'd4, 32'd7, 32'd2, 32'd7);
    do_scan(0, -1, -1);
    check_results("basic", 15, AW'(1), 32'd9, AW'(0), 32'd7);
  endtask

  task automatic test_sign_mode();
    load(32'hFFFF_FFFF, 32'h1, 32'h0, 32'd5, 32'd5, 32'd5);
    do_scan(0, -1, -1);
`ifdef ARGMAX_SIGNED_COMPARE_EN
    check_results("signed", 15, AW'(1), 32'h1, AW'(0), 32'd5);
`else
    check_results("unsigned", 15, AW'(0), 32'hFFFF_FFFF, AW'(0), 32'd5);
`endif
  endtask

  task automatic test_backpressure();
    load(32'd1, 32'd2, 32'd8, 32'd6, 32'd6, 32'd6);
    do_scan(10, -1, -1);
    check_results("stall", 25, AW'(2), 32'd8, AW'(0), 32'd6);
  endtask

  task automatic test_start_ignored();
    load(32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd45);
    do_scan(0, 8, -1);
    check_results("start_ignored", 15, AW'(2), 32'd30, AW'(1), 32'd50);
  endtask

  task automatic test_reset_mid_scan();
    load(32'd4, 32'd0, 32'd6, 32'd1, 32'd9, 32'd3);
    do_scan(0, -1, 9);
    tests_run++;
    if (done_cnt !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: %0d done pulses, required 0", done_cnt);
    end
    do_scan(0, -1, -1);
    check_results("rescan", 15, AW'(2), 32'd6, AW'(1), 32'd9);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    bus.z_data = '0;
    load('0, '0, '0, '0, '0, '0);
    test_reset();
    test_basic();
    test_sign_mode();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
